wb_mem_tester: RTL

//  Pipelined Wishbone (B4) master that drives a memory slave such as wb_sdram: writes a pseudo-random

---
 rtl/wb_mem_tester_pkg.sv | 22 ++
 rtl/wb_mem_tester_lfsr_prng.sv | 30 +++
 rtl/wb_mem_tester.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/wb_mem_tester_pkg.sv
// Shared types and constants for the Wishbone memory tester.
package wb_mem_tester_pkg;

    // Run sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_WDRAIN = 3'd2,
        ST_READ   = 3'd3,
        ST_RDRAIN = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // One step of the pattern LFSR
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/wb_mem_tester_lfsr_prng.sv
// 32-bit pattern LFSR: load has priority over step; exposes the low OUT_W bits.
module lfsr_prng
    import wb_mem_tester_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             sresetn,
    input  logic             i_load,
    input  logic [31:0]      i_seed,
    input  logic             i_step,
    output logic [OUT_W-1:0] o_value
);

    logic [31:0] r_value;

    // LFSR state register: reload with seed or advance one step
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= i_seed;
        end else if (i_step) begin
            r_value <= lfsr_next(r_value);
        end
    end

    assign o_value = r_value[OUT_W-1:0];

endmodule

// File: rtl/wb_mem_tester.sv
// Pipelined Wishbone B4 master: writes an LFSR pattern over an address window,
// reads it back, counts mismatches, aborts on a stuck slave via a watchdog.
module wb_mem_tester
    import wb_mem_tester_pkg::*;
#(
    parameter int          ADDR_BITS       = 23,
    parameter int          DATA_BYTES      = 2,
    parameter int          BASE_ADDR       = 0,
    parameter int          LENGTH          = 1024,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [31:0] LFSR_SEED       = 32'hACE1,
    parameter int          TIMEOUT         = 1024
) (
    input  logic                    clk,
    input  logic                    sresetn,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic [ADDR_BITS:0]      err_count,
    output logic [ADDR_BITS-1:0]    first_err_addr,
    output logic [ADDR_BITS-1:0]    m_wb_addr,
    output logic [DATA_BYTES*8-1:0] m_wb_dat_m2s,
    input  logic [DATA_BYTES*8-1:0] m_wb_dat_s2m,
    output logic                    m_wb_we,
    output logic [DATA_BYTES-1:0]   m_wb_sel,
    output logic                    m_wb_stb,
    output logic                    m_wb_cyc,
    input  logic                    m_wb_ack,
    input  logic                    m_wb_stall
);

    localparam int DW  = DATA_BYTES * 8;
    localparam int LW  = ADDR_BITS + 1;                   // holds LENGTH up to 2**ADDR_BITS
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int WDW = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_BITS-1:0] BASE   = ADDR_BITS'(BASE_ADDR);
    localparam logic [LW-1:0]        LEN    = LW'(LENGTH);
    localparam logic [CW-1:0]        MAXO   = CW'(MAX_OUTSTANDING);
    localparam logic [WDW-1:0]       WD_TOP = WDW'(TIMEOUT - 1);

    state_t                 r_state, w_next;
    logic [ADDR_BITS-1:0]   r_addr;       // request-side address
    logic [ADDR_BITS-1:0]   r_ack_addr;   // address of the read the next ack belongs to
    logic [LW-1:0]          r_issued;     // requests accepted in this phase
    logic [CW-1:0]          r_count;      // accepted but not yet acked
    logic [WDW-1:0]         r_wdog;
    logic [ADDR_BITS:0]     r_err;
    logic [ADDR_BITS-1:0]   r_first;
    logic                   r_timeout;

    logic                   w_active, w_issuing, w_stb, w_acc, w_ack;
    logic                   w_start, w_wdog_hit, w_phase_load, w_chk_ack, w_mismatch;
    logic [DW-1:0]          w_gen, w_chk;

    // Decoded state and handshake qualifiers
    assign w_active     = (r_state == ST_WRITE) || (r_state == ST_WDRAIN) ||
                          (r_state == ST_READ)  || (r_state == ST_RDRAIN);
    assign w_issuing    = (r_state == ST_WRITE) || (r_state == ST_READ);
    assign w_stb        = w_issuing && (r_issued != LEN) && (r_count != MAXO);
    assign w_acc        = w_stb && !m_wb_stall;
    // An ack with nothing outstanding is a protocol error from the slave; drop it.
    assign w_ack        = m_wb_ack && w_active && (r_count != '0);
    assign w_start      = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_wdog_hit   = w_active && (r_count != '0) && !m_wb_ack && (r_wdog == WD_TOP);
    // Both LFSRs restart from the seed at the top of each phase
    assign w_phase_load = w_start || ((r_state == ST_WDRAIN) && (r_count == '0));
    assign w_chk_ack    = w_ack && ((r_state == ST_READ) || (r_state == ST_RDRAIN));
    assign w_mismatch   = w_chk_ack && (m_wb_dat_s2m != w_chk);

    lfsr_prng #(.OUT_W(DW)) u_gen (
        .clk     (clk),
        .sresetn (sresetn),
        .i_load  (w_phase_load),
        .i_seed  (LFSR_SEED),
        .i_step  (w_acc && (r_state == ST_WRITE)),
        .o_value (w_gen)
    );

    lfsr_prng #(.OUT_W(DW)) u_chk (
        .clk     (clk),
        .sresetn (sresetn),
        .i_load  (w_phase_load),
        .i_seed  (LFSR_SEED),
        .i_step  (w_chk_ack),
        .o_value (w_chk)
    );

    // State register
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; the watchdog overrides every other transition
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start)              w_next = ST_WRITE;
            ST_WRITE:         if (r_issued == LEN)    w_next = ST_WDRAIN;
            ST_WDRAIN:        if (r_count == '0)      w_next = ST_READ;
            ST_READ:          if (r_issued == LEN)    w_next = ST_RDRAIN;
            ST_RDRAIN:        if (r_count == '0)      w_next = ST_DONE;
            default:                                  w_next = ST_IDLE;
        endcase
        if (w_wdog_hit) w_next = ST_DONE;
    end

    // Request side: address and issue counter restart per phase, advance on accept
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            r_addr   <= '0;
            r_issued <= '0;
        end else if (w_phase_load) begin
            r_addr   <= BASE;
            r_issued <= '0;
        end else if (w_acc) begin
            r_addr   <= r_addr + 1'b1;
            r_issued <= r_issued + 1'b1;
        end
    end

    // Outstanding counter; anything in flight is forgotten on start or abort
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            r_count <= '0;
        end else if (w_start || w_wdog_hit) begin
            r_count <= '0;
        end else begin
            case ({w_acc, w_ack})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Watchdog: cycles spent waiting on an ack, cleared whenever one arrives
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            r_wdog <= '0;
        end else if (w_start || w_wdog_hit || !w_active || (r_count == '0) || m_wb_ack) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    // Read checker: ack-side address, saturating error count, first failing address
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            r_ack_addr <= '0;
            r_err      <= '0;
            r_first    <= '0;
            r_timeout  <= 1'b0;
        end else if (w_start) begin
            r_ack_addr <= BASE;
            r_err      <= '0;
            r_first    <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_wdog_hit) r_timeout <= 1'b1;
            if (w_phase_load) begin
                r_ack_addr <= BASE;
            end else if (w_chk_ack) begin
                r_ack_addr <= r_ack_addr + 1'b1;
            end
            if (w_mismatch) begin
                if (r_err == '0) r_first <= r_ack_addr;
                if (r_err != '1) r_err   <= r_err + 1'b1;
            end
        end
    end

    assign busy           = w_active;
    assign done           = (r_state == ST_DONE);
    assign pass           = (r_state == ST_DONE) && (r_err == '0) && !r_timeout;
    assign timeout        = r_timeout;
    assign err_count      = r_err;
    assign first_err_addr = r_first;

    // Address and data only move on accept, so they hold through stalls
    assign m_wb_addr      = r_addr;
    assign m_wb_dat_m2s   = (r_state == ST_WRITE) ? w_gen : '0;
    assign m_wb_we        = (r_state == ST_WRITE);
    assign m_wb_sel       = '1;
    assign m_wb_stb       = w_stb;
    assign m_wb_cyc       = w_active;

endmodule
